snn_if_neuron: RTL and testbench



---
 rtl/snn_if_neuron.sv | 116 +++++++++++
 tb/tb_snn_if_neuron.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_if_neuron.sv
// ---------------------------------------------------------------------------
// snn_if_neuron
//   Integrate-and-fire spiking neuron with a host-writable signed weight
//   memory. Every clock edge is one timestep: the weights of all active
//   input spikes are summed into the membrane potential. When the potential
//   reaches THRESH, the neuron emits a one-cycle spike and the potential is
//   reloaded with RESET. There is no leak.
//
//   Optional feature (compile-time macro):
//     IF_NEURON_FLOOR_EN - clamp the next potential from below at RESET.
//
//   Ports
//     mem_clk   in   single clock for integration and weight memory
//     rst       in   async active-high reset (potential and spike only)
//     spike_in  in   [NUM_INPUTS]  spikes for this timestep, bit i -> weight i
//     spike_out out  registered spike, high one cycle per firing
//     mem_addr  in   [WEIGHT_ADDR_WIDTH] weight address (write and read)
//     mem_din   in   [WEIGHT_SIZE] weight write data
//     mem_wen   in   write enable
//     mem_dout  out  [WEIGHT_SIZE] registered read data (1-cycle latency)
// ---------------------------------------------------------------------------
module snn_if_neuron #(
  parameter int                             WEIGHT_SIZE       = 32,
  parameter logic signed [WEIGHT_SIZE-1:0]  THRESH            = 15,
  parameter logic signed [WEIGHT_SIZE-1:0]  RESET             = 0,
  parameter int                             NUM_INPUTS        = 4,
  parameter int                             WEIGHT_ADDR_WIDTH = 2
) (
  input  logic                         mem_clk,
  input  logic                         rst,
  input  logic [NUM_INPUTS-1:0]        spike_in,
  output logic                         spike_out,
  input  logic [WEIGHT_ADDR_WIDTH-1:0] mem_addr,
  input  logic [WEIGHT_SIZE-1:0]       mem_din,
  input  logic                         mem_wen,
  output logic [WEIGHT_SIZE-1:0]       mem_dout
);

  // Sum width holds NUM_INPUTS weights plus the current potential without
  // overflow, so saturation can be decided on the exact value.
  localparam int SUM_W = WEIGHT_SIZE + $clog2(NUM_INPUTS) + 1;
  localparam int EXT_W = SUM_W - WEIGHT_SIZE;

  localparam logic signed [SUM_W-1:0] LP_MAX =
    {{(EXT_W+1){1'b0}}, {(WEIGHT_SIZE-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] LP_MIN =
    {{(EXT_W+1){1'b1}}, {(WEIGHT_SIZE-1){1'b0}}};

  // Weights power up to zero and are deliberately outside the reset domain
  // so a neuron reset keeps the learned weights.
  logic [NUM_INPUTS-1:0][WEIGHT_SIZE-1:0] r_weight = '0;
  logic [WEIGHT_SIZE-1:0]                 r_dout   = '0;

  logic signed [WEIGHT_SIZE-1:0] r_v;
  logic                          r_spike;

  logic [WEIGHT_SIZE-1:0]        w_rd_data;
  logic signed [SUM_W-1:0]       w_sum;
  logic signed [SUM_W-1:0]       w_acc;
  logic signed [WEIGHT_SIZE-1:0] w_vsat;
  logic signed [WEIGHT_SIZE-1:0] w_vnext;
  logic                          w_fire;

  // Read mux with write-through: a read of the address being written
  // returns the new data. Out-of-range addresses read as zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (int'(mem_addr) == i) w_rd_data = mem_wen ? mem_din : r_weight[i];
  end

  always_ff @(posedge mem_clk) begin
    for (int i = 0; i < NUM_INPUTS; i++)
      if (mem_wen && int'(mem_addr) == i) r_weight[i] <= mem_din;
    r_dout <= w_rd_data;
  end

  // Integration reads r_weight before this edge's write lands, so a
  // same-edge write affects the next timestep only.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (spike_in[i])
        w_sum = w_sum + {{EXT_W{r_weight[i][WEIGHT_SIZE-1]}}, r_weight[i]};
  end

  assign w_acc = {{EXT_W{r_v[WEIGHT_SIZE-1]}}, r_v} + w_sum;

  always_comb begin
    if (w_acc > LP_MAX)      w_vsat = LP_MAX[WEIGHT_SIZE-1:0];
    else if (w_acc < LP_MIN) w_vsat = LP_MIN[WEIGHT_SIZE-1:0];
    else                     w_vsat = w_acc[WEIGHT_SIZE-1:0];
  end

`ifdef IF_NEURON_FLOOR_EN
  assign w_vnext = (w_vsat < RESET) ? RESET : w_vsat;
`else
  assign w_vnext = w_vsat;
`endif

  assign w_fire = (w_vnext >= THRESH);

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_v     <= RESET;
      r_spike <= 1'b0;
    end else begin
      r_spike <= w_fire;
      r_v     <= w_fire ? RESET : w_vnext;
    end
  end

  assign spike_out = r_spike;
  assign mem_dout  = r_dout;

endmodule

// File: tb/tb_snn_if_neuron.sv
// ---------------------------------------------------------------------------
// tb_snn_if_neuron
//   Directed bench for snn_if_neuron. A timestep-level model (integer
//   potential, weight array) predicts spike_out and mem_dout; a compare
//   process checks both DUT instances every cycle. A second instance with
//   THRESH at the positive limit covers positive saturation.
// ---------------------------------------------------------------------------
module tb_snn_if_neuron;

  localparam longint TH     = 15;
  localparam longint RS     = 0;
  localparam longint SAT_TH = 64'sd2147483647;
  localparam longint MAXV   = 64'sd2147483647;
  localparam longint MINV   = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  spk = '0;
  logic [1:0]  addr = '0;
  logic [31:0] din = '0;
  logic        wen = 1'b0;
  logic        spike_out;
  logic [31:0] mem_dout;

  logic [3:0]  s_spk = '0;
  logic [1:0]  s_addr = '0;
  logic [31:0] s_din = '0;
  logic        s_wen = 1'b0;
  logic        s_spike_out;
  logic [31:0] s_mem_dout;

  int n_vec = 0;
  int n_err = 0;
  int n_spk = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  snn_if_neuron u_dut (
    .mem_clk(clk), .rst(rst), .spike_in(spk), .spike_out(spike_out),
    .mem_addr(addr), .mem_din(din), .mem_wen(wen), .mem_dout(mem_dout)
  );

  snn_if_neuron #(.THRESH(32'sh7FFFFFFF)) u_sat (
    .mem_clk(clk), .rst(rst), .spike_in(s_spk), .spike_out(s_spike_out),
    .mem_addr(s_addr), .mem_din(s_din), .mem_wen(s_wen), .mem_dout(s_mem_dout)
  );

  // ---------------- model ----------------
  longint      m_w [4] = '{default: 0};
  longint      m_v = RS;
  logic        m_spk = 1'b0;
  logic [31:0] m_dout = '0;
  longint      ms_w [4] = '{default: 0};
  longint      ms_v = RS;
  logic        ms_spk = 1'b0;
  logic [31:0] ms_dout = '0;

  function automatic longint nxt(input longint v, input longint s);
    longint t;
    t = v + s;
    if (t > MAXV) t = MAXV;
    if (t < MINV) t = MINV;
`ifdef IF_NEURON_FLOOR_EN
    if (t < RS) t = RS;
`endif
    return t;
  endfunction

  always @(posedge clk) begin
    longint s, ss, t;
    s = 0; ss = 0;
    for (int i = 0; i < 4; i++) begin
      if (spk[i])   s  += m_w[i];
      if (s_spk[i]) ss += ms_w[i];
    end
    if (wen)   m_w[addr]    = longint'($signed(din));
    if (s_wen) ms_w[s_addr] = longint'($signed(s_din));
    m_dout  = 32'(m_w[addr]);
    ms_dout = 32'(ms_w[s_addr]);
    if (!rst) begin
      t = nxt(m_v, s);
      if (t >= TH) begin m_spk = 1'b1; m_v = RS; end
      else begin m_spk = 1'b0; m_v = t; end
      t = nxt(ms_v, ss);
      if (t >= SAT_TH) begin ms_spk = 1'b1; ms_v = RS; end
      else begin ms_spk = 1'b0; ms_v = t; end
    end
  end

  always @(posedge rst) begin
    m_v = RS;  m_spk = 1'b0;
    ms_v = RS; ms_spk = 1'b0;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (spike_out !== m_spk || mem_dout !== m_dout) begin
        n_err++;
        $display("FAIL cycle main t=%0t: spike_out=%b dout=%h, want spike_out=%b dout=%h",
                 $time, spike_out, mem_dout, m_spk, m_dout);
      end
      n_vec++;
      if (s_spike_out !== ms_spk || s_mem_dout !== ms_dout) begin
        n_err++;
        $display("FAIL cycle sat t=%0t: spike_out=%b dout=%h, want spike_out=%b dout=%h",
                 $time, s_spike_out, s_mem_dout, ms_spk, ms_dout);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [3:0] s, input int n);
    repeat (n) begin
      spk = s;
      @(negedge clk);
      if (spike_out) n_spk++;
    end
  endtask

  task automatic stick(input logic [3:0] s, input int n);
    repeat (n) begin
      s_spk = s;
      @(negedge clk);
      if (s_spike_out) n_spk++;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    spk = '0; addr = a; din = d; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic swr(input logic [1:0] a, input logic [31:0] d);
    s_spk = '0; s_addr = a; s_din = d; s_wen = 1'b1;
    @(negedge clk);
    s_wen = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    @(negedge clk);
    chk($sformatf("read w%0d", a), longint'(mem_dout), longint'(exp));
  endtask

  // Assert rst between edges and confirm spike_out clears without a clock.
  task automatic pulse_rst();
    spk = '0;
    #2 rst = 1'b1;
    #1 chk("async rst spike_out", longint'(spike_out), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // weight load and readback, then survive a reset
    wr(0, 32'hFFFFFFFF); wr(1, 32'd2); wr(2, 32'hFFFFFFFD); wr(3, 32'd4);
    rd_chk(0, 32'hFFFFFFFF); rd_chk(1, 32'd2); rd_chk(2, 32'hFFFFFFFD); rd_chk(3, 32'd4);
    pulse_rst();
    rd_chk(0, 32'hFFFFFFFF); rd_chk(1, 32'd2); rd_chk(2, 32'hFFFFFFFD); rd_chk(3, 32'd4);

    // sequential single-bit bursts: -1, 3, -6, 10 (floor: 0, 4, 0, fire)
    n_spk = 0;
    tick(4'b0001, 1); tick(0, 2);
    tick(4'b0010, 2); tick(0, 2);
    tick(4'b0100, 3); tick(0, 2);
    tick(4'b1000, 4); tick(0, 2);
`ifdef IF_NEURON_FLOOR_EN
    chk("seq spikes", n_spk, 1);
    chk("seq model v", m_v, 0);
`else
    chk("seq spikes", n_spk, 0);
    chk("seq model v", m_v, 10);
`endif

    // concurrent bursts, sum=2: 2, 6, 12, 14, fire, 2, 4
    pulse_rst();
    n_spk = 0;
    tick(4'hF, 1); tick(0, 1);
    tick(4'hF, 2); tick(0, 2);
    tick(4'hF, 3); tick(0, 3);
    tick(4'hF, 4); tick(0, 4);
    chk("conc spikes", n_spk, 1);
    chk("conc model v", m_v, 4);

    // async reset while spike_out is high
    pulse_rst();
    tick(4'hF, 8);
    chk("spike before rst", longint'(spike_out), 1);
    pulse_rst();

    // async reset at v=12: afterwards two all-on cycles give 2, 4, no spike
    tick(4'hF, 6);
    chk("v before rst", m_v, 12);
    pulse_rst();
    n_spk = 0;
    tick(4'hF, 2); tick(0, 1);
    chk("post-rst spikes", n_spk, 0);
    chk("post-rst model v", m_v, 4);

    // same-edge write to weight1 while bit1 integrates: old weight used
    pulse_rst();
    n_spk = 0;
    spk = 4'b0010; addr = 2'd1; din = 32'd10; wen = 1'b1;
    @(negedge clk);
    if (spike_out) n_spk++;
    wen = 1'b0;
    tick(4'b0010, 1);
    chk("wr-thru spikes", n_spk, 0);
    chk("wr-thru model v", m_v, 12);
    tick(4'b0010, 1);
    chk("wr-thru fire", n_spk, 1);
    wr(1, 32'd2);

    // negative saturation: potential pins at the minimum, no wrap
    wr(0, 32'h80000000);
    pulse_rst();
    n_spk = 0;
    tick(4'b0001, 3); tick(0, 1);
`ifdef IF_NEURON_FLOOR_EN
    chk("neg sat model v", m_v, 0);
`else
    chk("neg sat model v", m_v, MINV);
`endif
    chk("neg sat spikes", n_spk, 0);
    wr(0, 32'h7FFFFFFF);
    n_spk = 0;
    tick(4'b0001, 2); tick(0, 1);
`ifdef IF_NEURON_FLOOR_EN
    chk("neg sat recover", n_spk, 2);
`else
    chk("neg sat recover", n_spk, 1);
`endif

    // positive saturation, THRESH at max: 2^30 then clamp to max and fire
    swr(0, 32'h40000000);
    n_spk = 0;
    stick(4'b0001, 3); stick(0, 1);
    chk("pos sat spikes", n_spk, 1);
    swr(0, 32'h7FFFFFFF);
    n_spk = 0;
    stick(4'b0001, 3); stick(0, 1);
    chk("pos sat max spikes", n_spk, 3);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
